button_pulser: RTL and testbench

Game-input front end for the random-number game. It takes the three raw push-buttons (start, player 1, player 2), synchronizes and debounces each one, and issues exactly one single-cycle pulse per clean press. These pulses drive the game FSM's `start`, `P1_in` and `P2_in` inputs. It sits between the board pins and the game FSM, in the same `clk` domain.

---
 rtl/button_pulser_if.sv | 31 +++
 rtl/button_pulser.sv | 114 +++++++++++
 tb/tb_button_pulser.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/button_pulser_if.sv
// button_pulser_if: raw push-button inputs and debounced game-pulse outputs.
//   btn_start/btn_p1/btn_p2 : raw active-high buttons, asynchronous to clk
//   P_turn                  : whose turn it is (only with BUTTON_TURN_GATE_EN)
//   start/P1_in/P2_in       : one-cycle pulse per accepted press
//   btn_level               : debounced levels {p2, p1, start}
// Modports: master = board/pin side, slave = button_pulser.
`timescale 1ns/1ps
interface button_pulser_if;
    logic       btn_start;
    logic       btn_p1;
    logic       btn_p2;
`ifdef BUTTON_TURN_GATE_EN
    logic [1:0] P_turn;
`endif
    logic       start;
    logic       P1_in;
    logic       P2_in;
    logic [2:0] btn_level;

`ifdef BUTTON_TURN_GATE_EN
    modport master (output btn_start, btn_p1, btn_p2, P_turn,
                    input  start, P1_in, P2_in, btn_level);
    modport slave  (input  btn_start, btn_p1, btn_p2, P_turn,
                    output start, P1_in, P2_in, btn_level);
`else
    modport master (output btn_start, btn_p1, btn_p2,
                    input  start, P1_in, P2_in, btn_level);
    modport slave  (input  btn_start, btn_p1, btn_p2,
                    output start, P1_in, P2_in, btn_level);
`endif
endinterface

// File: rtl/button_pulser.sv
// button_pulser: synchronizes and debounces the start/P1/P2 buttons and emits
// one single-cycle pulse per clean press for the game FSM.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : button_pulser_if.slave (raw buttons in, pulses and levels out)
// Optional feature macro BUTTON_TURN_GATE_EN: gates P1_in/P2_in with P_turn.
`timescale 1ns/1ps
module button_pulser #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset_n,
    button_pulser_if.slave  bus
);
    localparam int unsigned NCH   = 3;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_RELEASED    = 2'd0;
    localparam logic [1:0] S_PRESS_CHK   = 2'd1;
    localparam logic [1:0] S_PRESSED     = 2'd2;
    localparam logic [1:0] S_RELEASE_CHK = 2'd3;

    logic [NCH-1:0]            sync1_q, sync1_d;
    logic [NCH-1:0]            sync2_q, sync2_d;
    logic [NCH-1:0]            pulse_q, pulse_d;
    logic [NCH-1:0]            level_q, level_d;
    logic [NCH-1:0][1:0]       state_q, state_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q,   cnt_d;

    // Channel order everywhere is {p2, p1, start}.
    always_comb begin
        sync1_d = {bus.btn_p2, bus.btn_p1, bus.btn_start};
        sync2_d = sync1_q;
    end

    // Per-channel debounce FSM; the counter restarts on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = '0;
        level_d = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            case (state_q[i])
                S_RELEASED: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_PRESS_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                S_PRESS_CHK: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_RELEASED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_PRESSED;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                S_PRESSED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_RELEASE_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_PRESSED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_RELEASED;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            endcase
            level_d[i] = (state_d[i] == S_PRESSED) || (state_d[i] == S_RELEASE_CHK);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pulse_q <= '0;
            level_q <= '0;
            state_q <= {NCH{S_RELEASED}};
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BUTTON_TURN_GATE_EN
    // Turn is checked during the pulse cycle itself; a suppressed press is lost.
    logic p1_turn, p2_turn;
    assign p1_turn = (bus.P_turn == 2'b01);
    assign p2_turn = (bus.P_turn == 2'b10);
`else
    logic p1_turn, p2_turn;
    assign p1_turn = 1'b1;
    assign p2_turn = 1'b1;
`endif

    assign bus.start     = pulse_q[0];
    assign bus.P1_in     = pulse_q[1] & p1_turn;
    assign bus.P2_in     = pulse_q[2] & p2_turn;
    assign bus.btn_level = level_q;
endmodule

// File: tb/tb_button_pulser.sv
// tb_button_pulser: directed scenarios with DEBOUNCE_CYCLES = 4; expected pulses
// are queued when a press is driven and matched as the DUT emits them.
`timescale 1ns/1ps
module tb_button_pulser;
    localparam int unsigned DEB     = 4;
    localparam int          LATENCY = int'(DEB) + 3;

    typedef struct {
        int         cyc;
        logic [2:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    button_pulser_if bus();

    button_pulser #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] pulses();
        return {bus.P2_in, bus.P1_in, bus.start};
    endfunction

    function automatic logic [2:0] exp_mask(logic [2:0] m);
`ifdef BUTTON_TURN_GATE_EN
        return m & {bus.P_turn == 2'b10, bus.P_turn == 2'b01, 1'b1};
`else
        return m;
`endif
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Queue one expected pulse event LATENCY edges after the current drive point.
    task automatic push(logic [2:0] m);
        exp_t e;
        e.mask = exp_mask(m);
        e.cyc  = cyc + LATENCY;
        if (e.mask != 3'b000) exp_q.push_back(e);
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        if (pulses() != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'b0, pulses()}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_cycle", cyc, mon_e.cyc);
                check("pulse_mask", {29'b0, pulses()}, {29'b0, mon_e.mask});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bounce [6];
        bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.btn_start = 1'b0;
        bus.btn_p1    = 1'b0;
        bus.btn_p2    = 1'b0;
`ifdef BUTTON_TURN_GATE_EN
        bus.P_turn    = 2'b01;
`endif
        rst_n = 1'b0;
        cycles(2);
        check("reset_level", {29'b0, bus.btn_level}, 32'd0);
        check("reset_pulses", {29'b0, pulses()}, 32'd0);
        rst_n = 1'b1;
        cycles(3);

        // Clean press on P1
        bus.btn_p1 = 1'b1;
        push(3'b010);
        cycles(LATENCY - 1);
        check("p1_level_pre", {29'b0, bus.btn_level}, 32'b000);
        cycles(1);
        check("p1_level_rise", {29'b0, bus.btn_level}, 32'b010);
        cycles(13);
        bus.btn_p1 = 1'b0;
        cycles(LATENCY - 1);
        check("p1_level_hold", {29'b0, bus.btn_level}, 32'b010);
        cycles(1);
        check("p1_level_fall", {29'b0, bus.btn_level}, 32'b000);
        cycles(13);

        // Bouncing start press: only the final rise counts
        for (int k = 0; k < 6; k++) begin
            bus.btn_start = bounce[k];
            if (k == 5) push(3'b001);
            cycles(1);
        end
        cycles(LATENCY - 1);
        check("start_level", {29'b0, bus.btn_level}, 32'b001);
        cycles(10);
        bus.btn_start = 1'b0;
        cycles(12);
        check("start_released", {29'b0, bus.btn_level}, 32'b000);

        // P2 held with a short release glitch
        bus.btn_p2 = 1'b1;
        push(3'b100);
        cycles(12);
        bus.btn_p2 = 1'b0;
        cycles(2);
        bus.btn_p2 = 1'b1;
        cycles(1);
        check("p2_glitch_level_a", {29'b0, bus.btn_level}, 32'b100);
        cycles(11);
        check("p2_glitch_level_b", {29'b0, bus.btn_level}, 32'b100);
        bus.btn_p2 = 1'b0;
        cycles(12);
        check("p2_released", {29'b0, bus.btn_level}, 32'b000);

        // Simultaneous P1 and P2
        bus.btn_p1 = 1'b1;
        bus.btn_p2 = 1'b1;
        push(3'b110);
        cycles(12);
        check("simul_level", {29'b0, bus.btn_level}, 32'b110);
        bus.btn_p1 = 1'b0;
        bus.btn_p2 = 1'b0;
        cycles(12);
        check("simul_released", {29'b0, bus.btn_level}, 32'b000);

        // Reset during start press check, with P2 already held
        bus.btn_p2 = 1'b1;
        push(3'b100);
        cycles(12);
        check("pre_reset_level", {29'b0, bus.btn_level}, 32'b100);
        bus.btn_start = 1'b1;
        cycles(4);
        rst_n = 1'b0;
        #1;
        check("rst_async_level", {29'b0, bus.btn_level}, 32'd0);
        check("rst_async_pulse", {29'b0, pulses()}, 32'd0);
        cycles(5);
        rst_n = 1'b1;
        push(3'b101);
        cycles(LATENCY - 1);
        check("post_reset_level_pre", {29'b0, bus.btn_level}, 32'b000);
        cycles(1);
        check("post_reset_level", {29'b0, bus.btn_level}, 32'b101);
        bus.btn_start = 1'b0;
        bus.btn_p2    = 1'b0;
        cycles(12);
        check("post_reset_released", {29'b0, bus.btn_level}, 32'b000);

`ifdef BUTTON_TURN_GATE_EN
        // P2's turn: P1 press suppressed, P2 press passes
        bus.P_turn = 2'b10;
        bus.btn_p1 = 1'b1;
        push(3'b010);
        cycles(LATENCY);
        check("gate_p1_level", {29'b0, bus.btn_level}, 32'b010);
        cycles(5);
        bus.btn_p1 = 1'b0;
        cycles(12);
        bus.btn_p2 = 1'b1;
        push(3'b100);
        cycles(12);
        check("gate_p2_level", {29'b0, bus.btn_level}, 32'b100);
        bus.btn_p2 = 1'b0;
        cycles(12);
`endif

        cycles(5);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
